// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller, datapath and ALU decoder:
// opcodes, ALU op classes, FSM states and the per-state control word.
package mips_ctrl_pkg;

    localparam int OP_W = 6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        ALU_WB   = 4'd7,
        BEQ_EX   = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        ORI_EX   = 4'd11,
        JUMP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW};
    endfunction

    // Raw Moore control word; write strobes are gated by enable/reset at the output.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:    c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            RTYPE_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            ALU_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BEQ_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ORI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_OR;
            end
            ADDI_WB:  c.reg_write = 1'b1;
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_control_unit_if.sv
// Controller <-> datapath bundle: instruction opcode and zero flag in, selects/strobes out.
interface mips_control_unit_if #(
    parameter int OPCODE_WIDTH = 6,
    parameter int STATE_WIDTH  = 4
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero;
    logic                    iord;
    logic                    mem_write;
    logic                    ir_write;
    logic                    reg_dst;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    alu_src_a;
    logic [1:0]              alu_src_b;
    logic [1:0]              alu_op;
    logic [1:0]              pc_src;
    logic                    pc_en;
    logic                    illegal;
    logic [STATE_WIDTH-1:0]  state;

    modport master (
        input  opcode, zero,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal, state
    );

    modport slave (
        output opcode, zero,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal, state
    );
endinterface

// File: rtl/mips_control_unit.sv
// Multicycle MIPS main controller: Moore FSM whose control word is registered with
// the state; write strobes, pc_en and illegal are qualified by enable and reset.
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int STATE_WIDTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    mips_control_unit_if.master bus
);

    state_t           state_q;
    state_t           state_n;
    ctrl_t            ctrl_q;
    logic [OP_W-1:0]  op;
    logic             go;

    assign op = OP_W'(bus.opcode);

    // enable is an advance permission: when low, the state holds and no write
    // strobe (ir/mem/reg write, pc_en, illegal) fires; selects still follow state.
    assign go = enable & ~reset;

    always_comb begin
        state_n = FETCH;
        case (state_q)
            FETCH:  state_n = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = RTYPE_EX;
                    OP_BEQ:       state_n = BEQ_EX;
                    OP_ADDI:      state_n = ADDI_EX;
                    OP_ORI:       state_n = ORI_EX;
                    OP_J:         state_n = JUMP;
                    default:      state_n = FETCH;
                endcase
            end
            MEMADR:   state_n = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_n = MEMWB;
            RTYPE_EX: state_n = ALU_WB;
            ADDI_EX:  state_n = ADDI_WB;
            ORI_EX:   state_n = ADDI_WB;
            default:  state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_for(FETCH);
        end else if (enable) begin
            state_q <= state_n;
            ctrl_q  <= ctrl_for(state_n);
        end
    end

    assign bus.iord       = ctrl_q.iord;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.pc_src     = ctrl_q.pc_src;

    assign bus.mem_write  = ctrl_q.mem_write & go;
    assign bus.ir_write   = ctrl_q.ir_write & go;
    assign bus.reg_write  = ctrl_q.reg_write & go;
    assign bus.pc_en      = (ctrl_q.pc_write | (ctrl_q.branch & bus.zero)) & go;
    assign bus.illegal    = go & (state_q == DECODE) & ~op_supported(op);
    assign bus.state      = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_mips_control_unit.sv
// Self-checking bench for mips_control_unit: directed scenarios plus a randomized
// instruction stream checked against a per-instruction sequence and control-table model.
module tb_mips_control_unit;
    import mips_ctrl_pkg::*;

    localparam int W = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mips_control_unit_if #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) bus ();

    mips_control_unit #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    function automatic logic [W-1:0] observed();
        return {bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                bus.pc_en, bus.illegal};
    endfunction

    // Control table as written in the instruction-step description.
    function automatic logic [W-1:0] model_word(input state_t st, input logic z,
                                                input logic en, input logic rst,
                                                input logic [5:0] op);
        logic iord, mw, irw, rd, m2r, rw, asa, pcw, br, ill, live;
        logic [1:0] asb, aop, psrc;
        {iord, mw, irw, rd, m2r, rw, asa, pcw, br, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            FETCH:    begin asb = 2'b01; irw = 1'b1; pcw = 1'b1; end
            DECODE:   begin asb = 2'b11; ill = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ORI, OP_J}); end
            MEMADR:   begin asa = 1'b1; asb = 2'b10; end
            MEMRD:    iord = 1'b1;
            MEMWB:    begin m2r = 1'b1; rw = 1'b1; end
            MEMWR:    begin iord = 1'b1; mw = 1'b1; end
            RTYPE_EX: begin asa = 1'b1; aop = 2'b10; end
            ALU_WB:   begin rd = 1'b1; rw = 1'b1; end
            BEQ_EX:   begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; br = 1'b1; end
            ADDI_EX:  begin asa = 1'b1; asb = 2'b10; end
            ORI_EX:   begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
            ADDI_WB:  rw = 1'b1;
            JUMP:     begin psrc = 2'b10; pcw = 1'b1; end
            default:  ;
        endcase
        live = en && !rst;
        return {iord, mw & live, irw & live, rd, m2r, rw & live, asa, asb, aop, psrc,
                (pcw | (br & z)) & live, ill & live};
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (op)
            OP_LW:                              return 5;
            OP_SW, OP_RTYPE, OP_ADDI, OP_ORI:   return 4;
            OP_BEQ, OP_J:                       return 3;
            default:                            return 2;
        endcase
    endfunction

    function automatic state_t seq_at(input logic [5:0] op, input int k);
        if (k == 0) return FETCH;
        if (k == 1) return DECODE;
        case (op)
            OP_LW:    return (k == 2) ? MEMADR : (k == 3) ? MEMRD : MEMWB;
            OP_SW:    return (k == 2) ? MEMADR : MEMWR;
            OP_RTYPE: return (k == 2) ? RTYPE_EX : ALU_WB;
            OP_ADDI:  return (k == 2) ? ADDI_EX : ADDI_WB;
            OP_ORI:   return (k == 2) ? ORI_EX : ADDI_WB;
            OP_BEQ:   return BEQ_EX;
            OP_J:     return JUMP;
            default:  return FETCH;
        endcase
    endfunction

    task automatic cycle(input logic en, input logic z, input logic rst, input logic [5:0] op);
        @(negedge clk);
        enable = en;
        bus.zero = z;
        reset = rst;
        bus.opcode = op;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(i == 0, 1'($urandom), 1'b1, 6'($urandom));
            n_checks++;
            if ({bus.mem_write, bus.ir_write, bus.reg_write, bus.pc_en, bus.illegal} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_strobes[%0d]: got %b want 00000", i,
                         {bus.mem_write, bus.ir_write, bus.reg_write, bus.pc_en, bus.illegal});
            end
        end
        cycle(1'b0, 1'b0, 1'b0, OP_LW);
        n_checks++;
        if (bus.state !== 4'(FETCH) || observed() !== model_word(FETCH, 1'b0, 1'b0, 1'b0, OP_LW)) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d word=%h want state=%0d word=%h", bus.state,
                     observed(), FETCH, model_word(FETCH, 1'b0, 1'b0, 1'b0, OP_LW));
        end
    endtask

    task automatic test_instr(input string name, input logic [5:0] op, input logic z);
        for (int k = 0; k < latency(op); k++) begin
            state_t st;
            logic [W-1:0] ew;
            st = seq_at(op, k);
            cycle(1'b1, z, 1'b0, op);
            ew = model_word(st, z, 1'b1, 1'b0, op);
            n_checks++;
            if (bus.state !== 4'(st) || observed() !== ew) begin
                n_fail++;
                $display("FAIL %s step %0d: state=%0d word=%h want state=%0d word=%h",
                         name, k, bus.state, observed(), st, ew);
            end
        end
    endtask

    task automatic test_lw();
        test_instr("lw", OP_LW, 1'($urandom));
    endtask

    task automatic test_beq();
        test_instr("beq_taken", OP_BEQ, 1'b1);
        test_instr("beq_not_taken", OP_BEQ, 1'b0);
    endtask

    task automatic test_sw_stall();
        state_t sts[8] = '{FETCH, DECODE, MEMADR, MEMADR, MEMADR, MEMADR, MEMWR, MEMWR};
        logic   ens[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ew;
            cycle(ens[i], 1'b1, 1'b0, OP_SW);
            ew = model_word(sts[i], 1'b1, ens[i], 1'b0, OP_SW);
            n_checks++;
            if (bus.state !== 4'(sts[i]) || observed() !== ew) begin
                n_fail++;
                $display("FAIL sw_stall step %0d: state=%0d word=%h want state=%0d word=%h",
                         i, bus.state, observed(), sts[i], ew);
            end
        end
    endtask

    task automatic test_illegal();
        state_t sts[4] = '{FETCH, DECODE, DECODE, FETCH};
        logic   ens[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] ew;
            cycle(ens[i], 1'b1, 1'b0, 6'b111111);
            ew = model_word(sts[i], 1'b1, ens[i], 1'b0, 6'b111111);
            n_checks++;
            if (bus.state !== 4'(sts[i]) || observed() !== ew) begin
                n_fail++;
                $display("FAIL illegal step %0d: state=%0d word=%h want state=%0d word=%h",
                         i, bus.state, observed(), sts[i], ew);
            end
        end
    endtask

    task automatic test_reset_in_alu_wb();
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, OP_RTYPE);
        cycle(1'b1, 1'b1, 1'b1, OP_RTYPE);
        n_checks++;
        if (bus.state !== 4'(ALU_WB) || bus.reg_write !== 1'b0 || bus.pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alu_wb: state=%0d reg_write=%b pc_en=%b want state=%0d 0 0",
                     bus.state, bus.reg_write, bus.pc_en, ALU_WB);
        end
        cycle(1'b0, 1'b0, 1'b0, OP_RTYPE);
        n_checks++;
        if (bus.state !== 4'(FETCH) || observed() !== model_word(FETCH, 1'b0, 1'b0, 1'b0, OP_RTYPE)) begin
            n_fail++;
            $display("FAIL reset_alu_wb_after: state=%0d word=%h want state=%0d word=%h",
                     bus.state, observed(), FETCH, model_word(FETCH, 1'b0, 1'b0, 1'b0, OP_RTYPE));
        end
    endtask

    task automatic test_back_to_back();
        test_instr("b2b_addi", OP_ADDI, 1'($urandom));
        test_instr("b2b_ori", OP_ORI, 1'($urandom));
        test_instr("b2b_j", OP_J, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] ops[9] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ORI, OP_J,
                               6'b111111, 6'b010101};
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            int k;
            op = ops[$urandom_range(0, 8)];
            k = 0;
            while (k < latency(op)) begin
                state_t st;
                logic en, z;
                logic [5:0] drv;
                logic [W-1:0] ew;
                st = seq_at(op, k);
                en = ($urandom_range(0, 3) != 0);
                z = 1'($urandom);
                // Opcode is only meaningful while decoding or addressing memory.
                drv = (st == DECODE || st == MEMADR) ? op : 6'($urandom);
                cycle(en, z, 1'b0, drv);
                exp_q.push_back(model_word(st, z, en, 1'b0, drv));
                ew = exp_q.pop_front();
                n_checks++;
                if (bus.state !== 4'(st) || observed() !== ew) begin
                    n_fail++;
                    $display("FAIL random op=%b step %0d: state=%0d word=%h want state=%0d word=%h",
                             op, k, bus.state, observed(), st, ew);
                end
                if (en) k++;
            end
        end
    endtask

    initial begin
        bus.opcode = 6'b0;
        bus.zero = 1'b0;
        test_reset();
        test_lw();
        test_beq();
        test_sw_stall();
        test_illegal();
        test_reset_in_alu_wb();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_control_unit.md
MIPS_CONTROL_UNIT -- requirements
Module: mips_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 6, width of opcode input.
REQ-002 SHALL have parameter STATE_WIDTH, default 4, width of debug state output.
REQ-003 SHALL have port clk  input  1  system clock; all state updates occur on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  advance permission; 0 freezes the FSM and suppresses all write strobes.
REQ-006 SHALL have port opcode  input  OPCODE_WIDTH  instruction bits [31:26] from the instruction register.
REQ-007 SHALL have port zero  input  1  ALU zero flag.
REQ-008 SHALL have ports iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  multicycle datapath selects and strobes.
REQ-009 SHALL have ports alu_src_b, alu_op, pc_src  output  2 each  ALU B-mux select, ALU op class, next-PC select.
REQ-010 SHALL have port pc_en  output  1  PC load enable = pc_write OR (branch AND zero).
REQ-011 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 SHALL have port state  output  STATE_WIDTH  current state encoding, for debug.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ALU_WB, BEQ_EX, ADDI_EX, ADDI_WB, ORI_EX, JUMP.
REQ-014 SHALL, with enable=1, transition as follows:
- FETCH->DECODE
- DECODE->MEMADR for lw 100011 or sw 101011; RTYPE_EX for 000000; BEQ_EX for 000100; ADDI_EX for 001000; ORI_EX for 001101; JUMP for 000010; FETCH otherwise
- MEMADR->MEMRD if lw, MEMWR if sw
- MEMRD->MEMWB
- RTYPE_EX->ALU_WB
- ADDI_EX->ADDI_WB
- ORI_EX->ADDI_WB
- MEMWB, MEMWR, ALU_WB, ADDI_WB, BEQ_EX, JUMP->FETCH
REQ-015 SHALL drive in FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1.
REQ-016 SHALL drive in DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-017 SHALL drive in MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. MEMRD: iord=1. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. MEMWR: iord=1, mem_write=1.
REQ-018 SHALL drive in RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10. ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1.
REQ-019 SHALL drive in BEQ_EX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
REQ-020 SHALL drive in ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. ORI_EX: same selects with alu_op=11. ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1.
REQ-021 SHALL drive in JUMP: pc_src=10, pc_write=1.
REQ-022 SHALL drive every output not listed for a state to 0.
REQ-023 SHALL compute pc_en combinationally from state and zero, with zero latency.
REQ-024 SHALL, when enable=0, hold the state register and force ir_write, mem_write, reg_write and pc_en to 0; mux selects remain per state.
REQ-025 SHALL assert illegal for exactly one cycle, in DECODE with enable=1, on an unsupported opcode; the FSM then returns to FETCH with no register or memory write.
REQ-026 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states have no effect.
REQ-027 SHALL give instruction latency (enable held 1) of lw=5, sw=4, R-type=4, addi=4, ori=4, beq=3, j=3 cycles.

Reset
REQ-028 SHALL load FETCH on a rising clk edge with reset=1, regardless of enable, aborting any instruction in progress.
REQ-029 SHALL drive, during reset, all write strobes, illegal and pc_en to 0; selects take their FETCH values from the next cycle.

Structure
REQ-030 SHALL take opcode constants, the state enumeration and the alu_op codes from shared package mips_ctrl_pkg, also used by the datapath and the ALU decoder.
REQ-031 SHALL keep the funct-to-ALU-control decode in a separate sub-module mips_alu_decoder, driven by alu_op and not instantiated in this block.

Verification
REQ-032 SHALL cover lw (100011) with enable=1: state FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 only in cycle 5.
REQ-033 SHALL cover beq (000100): zero=1 gives pc_en=1 in BEQ_EX with pc_src=01; zero=0 gives pc_en=0.
REQ-034 SHALL cover sw (101011) with enable dropped to 0 for 3 cycles in MEMADR: state held, mem_write=0 while stalled; mem_write=1 for one cycle in MEMWR once enable=1.
REQ-035 SHALL cover opcode 111111: illegal=1 for one cycle in DECODE, next state FETCH, no strobe asserted.
REQ-036 SHALL cover reset=1 asserted during ALU_WB: reg_write=0 in that cycle and state=FETCH after the edge.
REQ-037 SHALL cover back-to-back addi, ori, j: alu_op 00 then 11; JUMP asserts pc_src=10 and pc_en=1.
